// File: rtl/hazard_ctrl.sv
// Stall/flush control for the IF/ID register: load-use hold, branch flush, and the
// call and return stall sequences. Outputs are combinational on state and inputs.
module hazard_ctrl #(
  parameter int FLUSH_CYC = 2,
  parameter int CALL_CYC  = 1,
  parameter int RET_CYC   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] id_instr,
  input  logic        idex_mem_read,
  input  logic [3:0]  idex_rd,
  input  logic        ex_branch_taken,
  output logic        data_hazard,
  output logic        PC_hazard,
  output logic        call,
  output logic        ret_control,
  output logic        ret_PC,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_CALL_W = 2'd2,
    S_RET_W  = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_RLD   = 3'(FLUSH_CYC - 1);
  localparam logic [2:0] CALL_RLD    = 3'(CALL_CYC - 1);
  localparam logic [2:0] RET_RLD     = 3'(RET_CYC);
  localparam logic       FLUSH_MULTI = (FLUSH_CYC > 1);
  localparam logic       CALL_MULTI  = (CALL_CYC > 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_cnt;
  logic [2:0] w_next_cnt;
  logic [3:0] w_op;
  logic       w_load_use;
  logic       w_data_hazard;
  logic       w_pc_hazard;
  logic       w_call;
  logic       w_ret_control;
  logic       w_ret_pc;

  // True when the instruction in ID reads register rd as a source operand.
  function automatic logic reads_reg(input logic [15:0] instr, input logic [3:0] rd);
    logic hit;
    case (instr[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: hit = (instr[7:4] == rd) || (instr[3:0] == rd);
      4'h5, 4'h6, 4'h7, 4'h8:       hit = (instr[7:4] == rd);
      4'h9:                         hit = (instr[7:4] == rd) || (instr[11:8] == rd);
      4'hA:                         hit = (instr[11:8] == rd);
      default:                      hit = 1'b0;
    endcase
    return hit;
  endfunction

  assign w_op       = id_instr[15:12];
  assign w_load_use = idex_mem_read && (idex_rd != 4'd0) && reads_reg(id_instr, idex_rd);

  // Next-state, counter and raw output decode.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_data_hazard = 1'b0;
    w_pc_hazard   = 1'b0;
    w_call        = 1'b0;
    w_ret_control = 1'b0;
    w_ret_pc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ex_branch_taken) begin
          w_pc_hazard  = 1'b1;
          w_next_cnt   = FLUSH_RLD;
          w_next_state = FLUSH_MULTI ? S_FLUSH : S_IDLE;
        end else if (w_op == 4'hE) begin
          w_ret_control = 1'b1;
          w_next_cnt    = RET_RLD;
          w_next_state  = S_RET_W;
        end else if (w_op == 4'hD) begin
          w_call       = 1'b1;
          w_next_cnt   = CALL_RLD;
          w_next_state = CALL_MULTI ? S_CALL_W : S_IDLE;
        end else begin
          w_data_hazard = w_load_use;
        end
      end
      S_FLUSH: begin
        w_pc_hazard = 1'b1;
        if (ex_branch_taken) begin
          w_next_cnt   = FLUSH_RLD;
          w_next_state = FLUSH_MULTI ? S_FLUSH : S_IDLE;
        end else if (r_cnt <= 3'd1) begin
          w_next_cnt   = 3'd0;
          w_next_state = S_IDLE;
        end else begin
          w_next_cnt = r_cnt - 3'd1;
        end
      end
      S_CALL_W: begin
        if (ex_branch_taken) begin
          w_pc_hazard  = 1'b1;
          w_next_cnt   = FLUSH_RLD;
          w_next_state = FLUSH_MULTI ? S_FLUSH : S_IDLE;
        end else if (r_cnt <= 3'd1) begin
          w_call       = 1'b1;
          w_next_cnt   = 3'd0;
          w_next_state = S_IDLE;
        end else begin
          w_call     = 1'b1;
          w_next_cnt = r_cnt - 3'd1;
        end
      end
      S_RET_W: begin
        // A redirect during the return wait releases the halt and flushes together.
        if (ex_branch_taken) begin
          w_ret_pc     = 1'b1;
          w_pc_hazard  = 1'b1;
          w_next_cnt   = FLUSH_RLD;
          w_next_state = FLUSH_MULTI ? S_FLUSH : S_IDLE;
        end else if (r_cnt <= 3'd1) begin
          w_ret_pc     = 1'b1;
          w_next_cnt   = 3'd0;
          w_next_state = S_IDLE;
        end else begin
          w_next_cnt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_next_cnt   = 3'd0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Outputs are held low while reset is asserted.
  assign data_hazard = rst_n & w_data_hazard;
  assign PC_hazard   = rst_n & w_pc_hazard;
  assign call        = rst_n & w_call;
  assign ret_control = rst_n & w_ret_control;
  assign ret_PC      = rst_n & w_ret_pc;
  assign busy        = rst_n & (r_state != S_IDLE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Cycle-by-cycle scoreboard bench for hazard_ctrl (FLUSH_CYC=2, CALL_CYC=3, RET_CYC=3).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] id_instr;
  logic        idex_mem_read;
  logic [3:0]  idex_rd;
  logic        ex_branch_taken;
  logic        data_hazard;
  logic        PC_hazard;
  logic        call;
  logic        ret_control;
  logic        ret_PC;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [5:0]  sb_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(
    .FLUSH_CYC(2),
    .CALL_CYC (3),
    .RET_CYC  (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_instr       (id_instr),
    .idex_mem_read  (idex_mem_read),
    .idex_rd        (idex_rd),
    .ex_branch_taken(ex_branch_taken),
    .data_hazard    (data_hazard),
    .PC_hazard      (PC_hazard),
    .call           (call),
    .ret_control    (ret_control),
    .ret_PC         (ret_PC),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs[5:0], exp[5:0]);
    end
  endtask

  // exp bits: {data_hazard, PC_hazard, call, ret_control, ret_PC, busy}
  task automatic step(input string tag, input logic rst, input logic [15:0] instr,
                      input logic mr, input logic [3:0] rd, input logic br,
                      input logic [5:0] exp);
    logic [5:0] got;
    logic [5:0] want;
    rst_n           = rst;
    id_instr        = instr;
    idex_mem_read   = mr;
    idex_rd         = rd;
    ex_branch_taken = br;
    sb_q.push_back(exp);
    @(negedge clk);
    got  = {data_hazard, PC_hazard, call, ret_control, ret_PC, busy};
    want = sb_q.pop_front();
    chk(tag, {26'd0, got}, {26'd0, want});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset holds outputs low regardless of inputs
    step("rst_busy_in",   1'b0, 16'hF000, 1'b1, 4'd3, 1'b1, 6'b000000);
    step("rst_hold",      1'b0, 16'hE000, 1'b0, 4'd0, 1'b0, 6'b000000);
    step("idle",          1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    // load-use
    step("lu_add",        1'b1, 16'h0132, 1'b1, 4'd3, 1'b0, 6'b100000);
    step("lu_rd0",        1'b1, 16'h0132, 1'b1, 4'd0, 1'b0, 6'b000000);
    step("lu_llb",        1'b1, 16'hB3FF, 1'b1, 4'd3, 1'b0, 6'b000000);
    step("lu_noload",     1'b1, 16'h0132, 1'b0, 4'd3, 1'b0, 6'b000000);
    step("lu_sw",         1'b1, 16'h9312, 1'b1, 4'd3, 1'b0, 6'b100000);
    step("lu_lw",         1'b1, 16'h8430, 1'b1, 4'd3, 1'b0, 6'b100000);
    step("lu_lhb",        1'b1, 16'hA355, 1'b1, 4'd3, 1'b0, 6'b100000);
    step("lu_shift_hit",  1'b1, 16'h5134, 1'b1, 4'd3, 1'b0, 6'b100000);
    step("lu_shift_lo",   1'b1, 16'h5103, 1'b1, 4'd3, 1'b0, 6'b000000);
    // branch flush, load-use masked during flush
    step("br_c0",         1'b1, 16'h0132, 1'b1, 4'd3, 1'b1, 6'b010000);
    step("br_c1",         1'b1, 16'h0132, 1'b1, 4'd3, 1'b0, 6'b010001);
    step("br_done",       1'b1, 16'h0132, 1'b1, 4'd3, 1'b0, 6'b100000);
    // re-pulse restarts the flush
    step("rb_c0",         1'b1, 16'hF000, 1'b0, 4'd0, 1'b1, 6'b010000);
    step("rb_c1_repulse", 1'b1, 16'hF000, 1'b0, 4'd0, 1'b1, 6'b010001);
    step("rb_c2",         1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b010001);
    step("rb_done",       1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    // return sequence, second RET ignored, load-use masked while busy
    step("ret_ctl",       1'b1, 16'hE000, 1'b0, 4'd0, 1'b0, 6'b000100);
    step("ret_w1_2ndret", 1'b1, 16'hE000, 1'b0, 4'd0, 1'b0, 6'b000001);
    step("ret_w2_lu",     1'b1, 16'h0132, 1'b1, 4'd3, 1'b0, 6'b000001);
    step("ret_pc",        1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000011);
    step("ret_done",      1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    // call sequence
    step("call_c0",       1'b1, 16'hD123, 1'b0, 4'd0, 1'b0, 6'b001000);
    step("call_c1",       1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b001001);
    step("call_c2",       1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b001001);
    step("call_done",     1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    // branch during call wait
    step("cb_c0",         1'b1, 16'hD123, 1'b0, 4'd0, 1'b0, 6'b001000);
    step("cb_br",         1'b1, 16'hF000, 1'b0, 4'd0, 1'b1, 6'b010001);
    step("cb_flush",      1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b010001);
    step("cb_done",       1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    // branch beats RET and CALL in ID
    step("pri_ret_br",    1'b1, 16'hE000, 1'b0, 4'd0, 1'b1, 6'b010000);
    step("pri_ret_fl",    1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b010001);
    step("pri_ret_done",  1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    step("pri_call_br",   1'b1, 16'hD123, 1'b0, 4'd0, 1'b1, 6'b010000);
    step("pri_call_fl",   1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b010001);
    step("pri_call_done", 1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    // abort of return wait by branch
    step("ab_ret",        1'b1, 16'hE000, 1'b0, 4'd0, 1'b0, 6'b000100);
    step("ab_w1",         1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000001);
    step("ab_br",         1'b1, 16'hF000, 1'b0, 4'd0, 1'b1, 6'b010011);
    step("ab_flush",      1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b010001);
    step("ab_done",       1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    // reset in the middle of the return wait
    step("rr_ret",        1'b1, 16'hE000, 1'b0, 4'd0, 1'b0, 6'b000100);
    step("rr_w1",         1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000001);
    step("rr_rst",        1'b0, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    step("rr_after1",     1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    step("rr_after2",     1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 6'b000000);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
